// File: rtl/lane_merge_pkg.sv
// rtl/lane_merge_pkg.sv - shared constants, lane index type and pointer wrap helper for lane_merge
package lane_merge_pkg;

    localparam int MAX_LANES = 8;
    localparam int COUNT_W   = 16;

    typedef logic [2:0] lane_idx_t;

    // Round-robin successor of a lane index within an n-lane ring.
    function automatic lane_idx_t next_lane(input lane_idx_t idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/lane_merge_rr_arbiter.sv
// rtl/lane_merge_rr_arbiter.sv - round-robin arbiter: one-hot grant from req and a rotating pointer
module rr_arbiter
    import lane_merge_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    lane_idx_t ptr;
    lane_idx_t grant_idx;
    logic      found;

    // Scan lanes in priority order starting at ptr; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(ptr) + off) % N) == i)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = lane_idx_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= next_lane(grant_idx, N);
        end
    end

endmodule

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - N-lane round-robin merge into one registered word (+K); LANE_MERGE_COUNT_EN adds xfer_count
module lane_merge
    import lane_merge_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 32,
    parameter int K = 42
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_lane,
    input  logic                 out_ready
`ifdef LANE_MERGE_COUNT_EN
    ,
    output logic [COUNT_W-1:0]   xfer_count
`endif
);

    localparam int LW = $clog2(N);

    logic [N-1:0]  grant;
    logic          slot_free;
    logic          accept;
    logic [W-1:0]  lane_word [N];
    logic [LW-1:0] lane_tag  [N];
    logic [W-1:0]  sel_data;
    logic [LW-1:0] sel_lane;

    assign slot_free = !out_valid || out_ready;
    assign accept    = |in_ready;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (in_valid),
        .advance(accept),
        .grant  (grant)
    );

    // in_ready is gated by rst_n so it drops the moment reset asserts.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign in_ready[i]  = rst_n && slot_free && grant[i];
        assign lane_word[i] = grant[i] ? in_data[i*W +: W] : '0;
        assign lane_tag[i]  = grant[i] ? LW'(i) : '0;
    end

    // Grant is one-hot, so an OR across lanes acts as the mux.
    always_comb begin
        sel_data = '0;
        sel_lane = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | lane_word[i];
            sel_lane = sel_lane | lane_tag[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data + W'(K);
            out_lane  <= sel_lane;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LANE_MERGE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready && (xfer_count != '1)) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`else
`endif

endmodule

// File: doc/lane_merge.md
LANE_MERGE -- requirements
Module: lane_merge

Interface
REQ-001 SHALL have parameter N, default 2: number of input lanes, legal range 2..8.
REQ-002 SHALL have parameter W, default 32: data width in bits.
REQ-003 SHALL have parameter K, default 42: offset added to every merged word.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, N: per-lane word available.
REQ-007 SHALL have port in_data, input, N x W: per-lane words.
REQ-008 SHALL have port in_ready, output, N: per-lane accept strobe.
REQ-009 SHALL have port out_valid, output, 1: merged word held.
REQ-010 SHALL have port out_data, output, W: merged word, equal to the lane word + K.
REQ-011 SHALL have port out_lane, output, clog2(N): source lane of out_data.
REQ-012 SHALL have port out_ready, input, 1: consumer accept.

Function
REQ-013 SHALL treat a transfer as valid&&ready on the same edge, on both sides.
REQ-014 SHALL register one output entry; slot is free when !out_valid || out_ready.
REQ-015 SHALL assert in_ready[i] only for the granted lane, and only while the slot is free; at most one in_ready bit SHALL be high.
REQ-016 SHALL use a round-robin grant: the lowest-index valid lane at or after pointer ptr, wrapping N-1 -> 0.
REQ-017 SHALL set ptr to (granted lane + 1) mod N on each input transfer; otherwise ptr holds.
REQ-018 SHALL compute out_data = (in_data[lane] + K) mod 2^W, so that overflow wraps with no carry out.
REQ-019 SHALL have latency 1 cycle: a word accepted at edge t is visible on out_* after edge t.
REQ-020 SHALL hold out_valid, out_data and out_lane stable while out_valid && !out_ready.
REQ-021 SHALL support a simultaneous output drain and input accept on the same edge (full throughput, 1 word/cycle).
REQ-022 SHALL clear out_valid on an output transfer when no lane is granted.
REQ-023 SHALL make the grant depend only on in_valid and ptr, never on in_data.

Reset
REQ-024 SHALL, on rst_n low, immediately force out_valid=0, out_data=0, out_lane=0, ptr=0, and in_ready=0.
REQ-025 SHALL, on reset mid-transfer, discard the held word without emitting it; the first grant after release SHALL be from lane 0 onward.

Configuration
REQ-026 SHALL, with macro LANE_MERGE_COUNT_EN defined, add output port xfer_count (16 bits, reset value 0), which increments on each output transfer and saturates at 0xFFFF.
REQ-027 SHALL, without LANE_MERGE_COUNT_EN, omit the port and the counter logic entirely; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place in shared package lane_merge_pkg: MAX_LANES=8, COUNT_W=16, and the typedef lane_idx_t (logic [2:0]).
REQ-029 SHALL place the grant and pointer logic in sub-module rr_arbiter (parameter N; inputs req and advance; output one-hot grant).
REQ-030 SHALL build the per-lane in_ready and mux-select logic with a genvar generate loop over N.

Verification
REQ-031 SHALL be checked with a single-lane scenario: N=2, K=42, lane0 sends 0, out_ready=1 -> next cycle out_data=42, out_lane=0, in_ready[1]=0.
REQ-032 SHALL be checked with a round-robin scenario: both lanes valid continuously (lane0=1, lane1=1), out_ready=1 -> out_lane sequence 0,1,0,1 and out_data=43 each cycle.
REQ-033 SHALL be checked with a backpressure scenario: out_ready=0 for 3 cycles with lane1=9001 held -> out_data=9043 stable, in_ready=0; first out_ready=1 cycle -> transfer, and the next word is accepted on the same edge.
REQ-034 SHALL be checked with a wrap scenario: W=32, lane0 sends 0xFFFFFFF0 -> out_data=0x0000001A.
REQ-035 SHALL be checked with a reset scenario: rst_n pulsed low while out_valid=1 -> out_valid=0 within the same cycle, without waiting for clk; after release with both lanes valid, the first out_lane=0.
REQ-036 SHALL be checked with a counter scenario (LANE_MERGE_COUNT_EN defined): 70000 output transfers -> xfer_count=0xFFFF; with the macro undefined, the build SHALL have no xfer_count port.
